// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the unified memory responder
// Purpose: FSM state encoding, read/write mode codes and word geometry.
// Ports: none (package).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mem_state_t;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/unified_sram_array.sv
// rtl/unified_sram_array.sv - 1R/1W synchronous word array with byte-lane write enable
// Purpose: storage behind the responder; contents are deliberately not reset.
// Ports:
//   clk         in  clock, rising edge
//   rd_en_i     in  capture mem[rd_idx_i] into rd_data_o on the next edge
//   rd_idx_i    in  read word index
//   rd_data_o   out registered read word (held while rd_en_i is low)
//   wr_en_i     in  write strobe
//   wr_idx_i    in  write word index
//   wr_data_i   in  write word
//   wr_be_i     in  per-lane write enable
module unified_sram_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_be_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
    if (wr_en_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_be_i[i]) begin
          mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - single-request memory responder with wait states
// Purpose: accepts one request at a time, waits WAIT_STATES cycles, performs the
//   array access and pulses resp_valid with read data / range error.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   req_valid       request present (sampled only in IDLE)
//   mem_addr        byte address, bits [1:0] ignored
//   mem_rw_mode     1 = read, 0 = write
//   mem_write_data  write data, lane i = bits [8i+7:8i]
//   mem_byte_en     per-lane write enable
//   busy            request in flight
//   resp_valid      one-cycle response pulse
//   mem_read_data   read word (0 for writes / out of range), held until next response
//   resp_err        address beyond the array
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] mem_addr,
  input  logic        mem_rw_mode,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_byte_en,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] mem_read_data,
  output logic        resp_err
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam int          CNT_W   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  mem_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0] word_q, word_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_in_range;
  logic        lat_in_range;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_rd_data;

  // Byte-offset bits never select anything in a word-wide array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  assign accept       = (state_q == IDLE) && req_valid;
  assign req_in_range = {2'b00, mem_addr[31:2]} < DEPTH_L;
  assign lat_in_range = {2'b00, word_q} < DEPTH_L;

  // The read is launched from the live address at the accept edge so the
  // array output is already settled when ACCESS copies it, even with zero
  // wait states. Nothing writes the array between accept and ACCESS.
  assign sram_rd_en = accept && (mem_rw_mode == RW_READ) && req_in_range;
  assign sram_wr_en = (state_q == ACCESS) && (rw_q == RW_WRITE) && lat_in_range;

  unified_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .rd_en_i   (sram_rd_en),
    .rd_idx_i  (mem_addr[IDX_W+1:2]),
    .rd_data_o (sram_rd_data),
    .wr_en_i   (sram_wr_en),
    .wr_idx_i  (word_q[IDX_W-1:0]),
    .wr_data_i (wdata_q),
    .wr_be_i   (be_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d  = mem_addr[31:2];
          rw_d    = mem_rw_mode;
          wdata_d = mem_write_data;
          be_d    = mem_byte_en;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        err_d = !lat_in_range;
        if ((rw_q == RW_READ) && lat_in_range) begin
          rdata_d = sram_rd_data;
        end else begin
          rdata_d = '0;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q == WAIT) || (state_q == ACCESS);
  assign resp_valid    = (state_q == RESP);
  assign mem_read_data = rdata_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - directed self-checking bench for unified_mem_responder
module tb_unified_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_rw_mode = 1'b1;
  logic [31:0] mem_write_data = '0;
  logic [3:0]  mem_byte_en = '0;

  logic        busy_a, resp_valid_a, resp_err_a;
  logic [31:0] rd_a;
  logic        busy_b, resp_valid_b, resp_err_b;
  logic [31:0] rd_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid_a),
    .mem_addr       (mem_addr),
    .mem_rw_mode    (mem_rw_mode),
    .mem_write_data (mem_write_data),
    .mem_byte_en    (mem_byte_en),
    .busy           (busy_a),
    .resp_valid     (resp_valid_a),
    .mem_read_data  (rd_a),
    .resp_err       (resp_err_a)
  );

  unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid_b),
    .mem_addr       (mem_addr),
    .mem_rw_mode    (mem_rw_mode),
    .mem_write_data (mem_write_data),
    .mem_byte_en    (mem_byte_en),
    .busy           (busy_b),
    .resp_valid     (resp_valid_b),
    .mem_read_data  (rd_b),
    .resp_err       (resp_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? resp_valid_b : resp_valid_a;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Issue one request, check busy after accept and the accept-to-response
  // latency (accept edge counted as 1), and return the response fields.
  task automatic do_req(input string tag, input bit sel, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    mem_addr       = addr;
    mem_rw_mode    = rw;
    mem_write_data = wd;
    mem_byte_en    = be;
    if (sel) req_valid_b = 1'b1;
    else     req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    chk({tag, "_busy"}, {31'b0, get_busy(sel)}, 32'd1);
    lat = 1;
    got = 1'b0;
    rd  = 32'hBAD0_BAD0;
    err = 1'bx;
    while (!got && lat < 16) begin
      @(negedge clk);
      if (get_resp(sel)) begin
        got = 1'b1;
        rd  = sel ? rd_b : rd_a;
        err = sel ? resp_err_b : resp_err_a;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_resp", {31'b0, resp_valid_a}, 32'd0);
    chk("rst_rdata", rd_a, 32'h0);
    chk("rst_err", {31'b0, resp_err_a}, 32'd0);
    chk("rst_busy_b", {31'b0, busy_b}, 32'd0);
    rst_n = 1'b1;

    // 1: full write then read
    do_req("t1_wr", 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 4);
    chk("t1_wr_rdata", rd, 32'h0);
    chk("t1_wr_err", {31'b0, err}, 32'd0);
    do_req("t1_rd", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 4);
    chk("t1_rd_rdata", rd, 32'hDEAD_BEEF);

    // 2: single-lane merge
    do_req("t2_wr", 1'b0, 1'b0, 32'h10, 32'h0000_00AA, 4'b0001, 4);
    do_req("t2_rd", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 4);
    chk("t2_rd_rdata", rd, 32'hDEAD_BEAA);

    // 3: byte offset ignored
    do_req("t3_rd", 1'b0, 1'b1, 32'h13, 32'h0, 4'hF, 4);
    chk("t3_rdata", rd, 32'hDEAD_BEAA);
    chk("t3_err", {31'b0, err}, 32'd0);

    // 4: out of range; word 0 would be the aliased index
    do_req("t4_wr0", 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 4'hF, 4);
    do_req("t4_rd_oor", 1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, 4);
    chk("t4_oor_rdata", rd, 32'h0);
    chk("t4_oor_err", {31'b0, err}, 32'd1);
    do_req("t4_wr_oor", 1'b0, 1'b0, 32'h1000, 32'h1234_5678, 4'hF, 4);
    chk("t4_wr_oor_err", {31'b0, err}, 32'd1);
    do_req("t4_rd0", 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 4);
    chk("t4_rd0_rdata", rd, 32'hCAFE_F00D);
    chk("t4_rd0_err", {31'b0, err}, 32'd0);

    // 5: inputs change while busy, req_valid held through RESP
    @(negedge clk);
    mem_addr       = 32'h10;
    mem_rw_mode    = 1'b1;
    mem_write_data = 32'h0;
    mem_byte_en    = 4'h0;
    req_valid_a    = 1'b1;
    @(posedge clk);
    #1;
    mem_addr       = 32'h20;
    mem_rw_mode    = 1'b0;
    mem_write_data = 32'hFFFF_FFFF;
    mem_byte_en    = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("t5_busy", {31'b0, busy_a}, 32'd1);
      chk("t5_noresp", {31'b0, resp_valid_a}, 32'd0);
    end
    @(negedge clk);
    chk("t5_resp", {31'b0, resp_valid_a}, 32'd1);
    chk("t5_resp_busy", {31'b0, busy_a}, 32'd0);
    chk("t5_rdata", rd_a, 32'hDEAD_BEAA);
    @(negedge clk);
    chk("t5_no_accept_busy", {31'b0, busy_a}, 32'd0);
    chk("t5_no_accept_resp", {31'b0, resp_valid_a}, 32'd0);
    req_valid_a = 1'b0;

    // 6: reset during WAIT of a write
    do_req("t6_wr", 1'b0, 1'b0, 32'h20, 32'h1111_1111, 4'hF, 4);
    do_req("t6_rd10", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 4);
    chk("t6_rd10_rdata", rd, 32'hDEAD_BEAA);
    @(negedge clk);
    mem_addr       = 32'h20;
    mem_rw_mode    = 1'b0;
    mem_write_data = 32'h2222_2222;
    mem_byte_en    = 4'hF;
    req_valid_a    = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    @(negedge clk);
    chk("t6_pre_busy", {31'b0, busy_a}, 32'd1);
    chk("t6_pre_rdata", rd_a, 32'hDEAD_BEAA);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'b0, busy_a}, 32'd0);
    chk("t6_rst_resp", {31'b0, resp_valid_a}, 32'd0);
    chk("t6_rst_rdata", rd_a, 32'h0);
    chk("t6_rst_err", {31'b0, resp_err_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("t6_rd20", 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 4);
    chk("t6_rd20_rdata", rd, 32'h1111_1111);

    // 6b: zero wait states
    do_req("t6b_wr", 1'b1, 1'b0, 32'h20, 32'h1111_1111, 4'hF, 2);
    chk("t6b_wr_rdata", rd, 32'h0);
    do_req("t6b_rd", 1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 2);
    chk("t6b_rd_rdata", rd, 32'h1111_1111);
    do_req("t6b_oor", 1'b1, 1'b1, 32'h1004, 32'h0, 4'h0, 2);
    chk("t6b_oor_err", {31'b0, err}, 32'd1);
    chk("t6b_oor_rdata", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
